imm_gen_pipe: RTL
=================

# imm_gen_pipe

- Registered, handshaked immediate-generation stage for the decode path.
- Accepts one 32-bit instruction per cycle and classifies its format.
- Produces the XLEN-wide immediate, a format code, an illegal flag and a pass-through tag behind a valid/ready interface with a 2-entry skid buffer.
- Keeps a saturating count of illegal encodings delivered downstream.

## Interface
- `XLEN`, 32: datapath width, 32 or 64.
- `TAG_W`, 32: width of the opaque tag (normally PC) carried alongside.
- `CNT_W`, 16: width of the illegal-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous drop of all held entries.
- `in_valid` in 1: instruction offered.
- `in_ready` out 1: stage can accept.
- `inst` in 32: instruction word.
- `in_tag` in TAG_W: tag for `inst`.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts.
- `imm_o` out XLEN: immediate.
- `fmt_o` out 3: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR.
- `illegal_o` out 1: unsupported or malformed encoding.
- `tag_o` out TAG_W: tag of the delivered entry.
- `cnt_clr` in 1: synchronous counter clear.
- `ill_cnt` out CNT_W: saturating illegal count.

## Operation
- Decode is combinational on `inst`. All results are sign-extended to XLEN unless stated otherwise.
- `inst[1:0]` != 2'b11 → illegal, NONE, imm 0.
- LOAD 0000011, JALR 1100111 → I, `inst[31:20]`.
- OP-IMM 0010011:
  - funct3 001/101 → SHAMT, zero-extended `inst[24:20]` (XLEN=32) or `inst[25:20]` (XLEN=64).
  - XLEN=32 with `inst[25]`=1 in a shift → illegal.
  - Other funct3 → I.
- OP-IMM-32 0011011 (XLEN=64 only, else illegal): funct3 001/101 → SHAMT with `inst[24:20]`; others → I.
- STORE 0100011 → S, {`inst[31:25]`,`inst[11:7]`}.
- BRANCH 1100011 → B, {`inst[31]`,`inst[7]`,`inst[30:25]`,`inst[11:8]`,0}.
- LUI 0110111, AUIPC 0010111 → U, {`inst[31:12]`,12'h0} sign-extended from bit 31.
- JAL 1101111 → J, {`inst[31]`,`inst[19:12]`,`inst[20]`,`inst[30:21]`,0}.
- OP 0110011, MISC-MEM 0001111 → NONE, imm 0. OP-32 0111011 likewise, but illegal when XLEN=32.
- SYSTEM 1110011: see Configuration.
- Any other opcode → illegal, NONE, imm 0.
- Buffering:
  - Output register plus one skid entry.
  - `in_ready` = skid entry empty, registered.
  - Entries are delivered strictly in acceptance order, never dropped or duplicated except by `flush`.
- Counter:
  - Increments on each output transfer (`out_valid && out_ready`) with `illegal_o`=1.
  - Saturates at all-ones.
  - `cnt_clr` wins over a simultaneous increment; the result is 0.

## Timing
- Reset values: `out_valid` 0, `imm_o` 0, `fmt_o` 0, `illegal_o` 0, `tag_o` 0, `ill_cnt` 0, skid empty, `in_ready` 1.
- Accept on edge N (`in_valid && in_ready`) → `out_valid` high after edge N. Latency is 1 cycle.
- With `out_ready` held 1, throughput is 1 per cycle.
- While `out_valid && !out_ready`, all output fields are held stable.
- An accept during a stall fills the skid entry; `in_ready` falls after that edge.
- When the output transfers, the skid entry moves to the output register on the same edge and `in_ready` rises.
- Simultaneous output transfer and input accept with skid empty → new entry goes directly to the output register.
- `flush`:
  - Clears `out_valid` and the skid entry on the next edge.
  - `in_valid` in the flush cycle is not accepted (`in_ready` forced 0 that cycle).
  - The counter is unaffected.
- Async reset mid-stall discards all entries immediately.

## Configuration
- `IMMGEN_ZICSR_EN` defined, SYSTEM decoding:
  - funct3 000 → CSR, zero-extended `inst[31:20]`.
  - funct3 001/010/011 → CSR, zero-extended `inst[31:20]` (CSR address).
  - funct3 101/110/111 → CSR, {zero-extended `inst[19:15]`} in imm[4:0] and CSR address in imm[16:5].
  - funct3 100 → illegal.
- `IMMGEN_ZICSR_EN` undefined: every SYSTEM encoding → illegal, NONE, imm 0.

## Test plan
- XLEN=32, `out_ready`=1, back-to-back inputs:
  - 0xFFF00093 → I, 0xFFFFFFFF.
  - 0x4050D093 → SHAMT, 0x00000005.
  - 0xFE000EE3 → B, 0xFFFFFFFC.
  - Each appears 1 cycle after its accept, with tags in order.
- XLEN=64: 0x800000B7 → U, 0xFFFFFFFF80000000. 0x03F09093 → SHAMT, 0x3F.
- Hold `out_ready`=0 and offer tags 1,2,3 → 1 and 2 accepted, `in_ready`=0, output frozen on tag 1. Release → tags 1,2 then 3, no loss or duplicate.
- CNT_W=2, deliver 0x00000000 four times → `ill_cnt` 1,2,3,3. Assert `cnt_clr` together with a fifth illegal transfer → 0.
- With entries held, pulse `flush` while `in_valid`=1 → `out_valid`=0 next cycle, offered input not accepted. Repeat with `rst_n` low mid-stall → all outputs at reset values immediately.
- 0x300110F3:
  - With `IMMGEN_ZICSR_EN` → CSR, 0x300, illegal 0.
  - Without → illegal 1, imm 0, count +1.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_o;
    logic [2:0]       fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] tag_o;

    modport master (
        output in_valid, inst, in_tag, out_ready,
        input  in_ready, out_valid, imm_o, fmt_o, illegal_o, tag_o
    );

    modport slave (
        input  in_valid, inst, in_tag, out_ready,
        output in_ready, out_valid, imm_o, fmt_o, illegal_o, tag_o
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer and illegal counter
// Optional SYSTEM/CSR immediate decoding is enabled by defining IMMGEN_ZICSR_EN.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             cnt_clr,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] ill_cnt
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_32    = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_CSR   = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       fmt;
        logic             ill;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;

    assign inst     = bus.inst;
    assign opcode   = inst[6:0];
    assign funct3   = inst[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Every immediate is first formed as a 32-bit value; the zero-extended
    // kinds never set bit 31, so one sign extension to XLEN covers them all.
    logic [31:0] dec_val;
    fmt_e        dec_fmt;
    logic        dec_ill;

    always_comb begin
        dec_val = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (opcode[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD, OPC_JALR: begin
                    dec_fmt = FMT_I;
                    dec_val = {{20{inst[31]}}, inst[31:20]};
                end
                OPC_OP_IMM: begin
                    if (!is_shift) begin
                        dec_fmt = FMT_I;
                        dec_val = {{20{inst[31]}}, inst[31:20]};
                    end else if (IS64) begin
                        dec_fmt = FMT_SHAMT;
                        dec_val = {26'b0, inst[25:20]};
                    end else if (inst[25]) begin
                        dec_ill = 1'b1;
                    end else begin
                        dec_fmt = FMT_SHAMT;
                        dec_val = {27'b0, inst[24:20]};
                    end
                end
                OPC_OP_IMM32: begin
                    if (!IS64) begin
                        dec_ill = 1'b1;
                    end else if (is_shift) begin
                        dec_fmt = FMT_SHAMT;
                        dec_val = {27'b0, inst[24:20]};
                    end else begin
                        dec_fmt = FMT_I;
                        dec_val = {{20{inst[31]}}, inst[31:20]};
                    end
                end
                OPC_STORE: begin
                    dec_fmt = FMT_S;
                    dec_val = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                end
                OPC_BRANCH: begin
                    dec_fmt = FMT_B;
                    dec_val = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec_fmt = FMT_U;
                    dec_val = {inst[31:12], 12'h000};
                end
                OPC_JAL: begin
                    dec_fmt = FMT_J;
                    dec_val = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                end
                OPC_OP, OPC_MISC_MEM: dec_ill = 1'b0;
                OPC_OP_32:            dec_ill = !IS64;
                OPC_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
                    case (funct3)
                        3'b100: dec_ill = 1'b1;
                        3'b101, 3'b110, 3'b111: begin
                            dec_fmt = FMT_CSR;
                            dec_val = {15'b0, inst[31:20], inst[19:15]};
                        end
                        default: begin
                            dec_fmt = FMT_CSR;
                            dec_val = {20'b0, inst[31:20]};
                        end
                    endcase
`else
                    dec_ill = 1'b1;
`endif
                end
                default: dec_ill = 1'b1;
            endcase
        end
        if (dec_ill) begin
            dec_fmt = FMT_NONE;
            dec_val = '0;
        end
    end

    entry_t dec_entry;
    assign dec_entry.imm = XLEN'($signed(dec_val));
    assign dec_entry.fmt = dec_fmt;
    assign dec_entry.ill = dec_ill;
    assign dec_entry.tag = bus.in_tag;

    entry_t           out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready;
    logic             accept;
    logic             xfer;

    assign in_ready = !skid_valid_q && !flush;
    assign accept   = bus.in_valid && in_ready;
    assign xfer     = out_valid_q && bus.out_ready;

    // The output register refills from the skid entry first so acceptance
    // order is preserved; a new input only bypasses into it when skid is empty.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec_entry;
                end
            end
        end else if (accept) begin
            skid_d       = dec_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (xfer && out_q.ill && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.imm_o     = out_q.imm;
    assign bus.fmt_o     = out_q.fmt;
    assign bus.illegal_o = out_q.ill;
    assign bus.tag_o     = out_q.tag;
    assign ill_cnt       = cnt_q;
endmodule
